// File: rtl/mult_share_arbiter_if.sv
// Bundle of client request, response and multiplier-side signals for mult_share_arbiter.
// slave: arbiter view. master: the side that plays requesters, response sink and multiplier.
interface mult_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [63:0]           rsp_product;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_err;
  logic                  mul_start;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic                  mul_busy;
  logic [63:0]           mul_product;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_busy, mul_product,
    output req_ready, rsp_valid, rsp_product, rsp_id, rsp_err, mul_start, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_busy, mul_product,
    input  req_ready, rsp_valid, rsp_product, rsp_id, rsp_err, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle 32x32 multiplier among NUM_REQ requesters.
// One operation in flight; the result comes back on a single backpressured response port.
// ID_W must equal $clog2(NUM_REQ); TIMEOUT bounds the wait for the multiplier (4..255).
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset,
  mult_share_arbiter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StStart, StWaitHi, StWaitLo, StResp} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [63:0]        prod_q, prod_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [31:0]        sel_a, sel_b;
  logic               timeout_hit;

  // First valid requester at or above rr_q, wrapping around.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_q) + i) % NUM_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        sel_a      = bus.req_a[32*idx +: 32];
        sel_b      = bus.req_b[32*idx +: 32];
      end
    end
  end

  // Watchdog: this cycle is the TIMEOUT-th spent waiting on the multiplier.
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT);

  // Next-state and Moore/Mealy outputs.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    a_d           = a_q;
    b_d           = b_q;
    prod_d        = prod_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    bus.req_ready = '0;
    bus.mul_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Ready only on the granted line, so a grant is always a transfer.
        bus.req_ready = grant;
        if (grant_any) begin
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = grant_idx;
          prod_d  = '0;
          err_d   = 1'b0;
          rr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        bus.mul_start = 1'b1;
        cnt_d         = '0;
        state_d       = StWaitHi;
      end
      StWaitHi: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.mul_busy) begin
          state_d = StWaitLo;
        end else if (timeout_hit) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StWaitLo: begin
        cnt_d = cnt_q + 8'd1;
        if (!bus.mul_busy) begin
          prod_d  = bus.mul_product;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout_hit) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs straight from the latches; they stay stable under backpressure.
  assign bus.rsp_valid   = (state_q == StResp);
  assign bus.rsp_product = prod_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_err     = err_q;
  assign bus.mul_a       = a_q;
  assign bus.mul_b       = b_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rr_q    <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier and a response scoreboard.
`timescale 1ns/1ps
module tb_mult_share_arbiter;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned BUSY_CYC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stuck = 1'b0;

  always #5 clk = ~clk;

  mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural multi-cycle multiplier: busy for BUSY_CYC cycles after start.
  logic        m_busy;
  logic [63:0] m_prod;
  logic [7:0]  m_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_prod <= '0;
      m_cnt  <= '0;
    end else if (bus.mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 8'(BUSY_CYC);
      m_prod <= 64'(bus.mul_a) * 64'(bus.mul_b);
    end else if (m_busy) begin
      if (m_cnt == 8'd1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 8'd1;
    end
  end
  assign bus.mul_busy    = stuck | m_busy;
  assign bus.mul_product = m_prod;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     prod;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_rsp  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [63:0] prod, input logic err);
    exp_t e;
    e.id   = id;
    e.prod = prod;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Monitor: every response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d product 0x%0h, expected no response",
                 bus.rsp_id, bus.rsp_product);
      end else begin
        e = sb.pop_front();
        chk("rsp_product", bus.rsp_product, e.prod);
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1 with the DUT idle; ends at the negedge after the start pulse.
  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input string nm);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    bus.req_a[32*idx +: 32] = a;
    bus.req_b[32*idx +: 32] = b;
    bus.req_valid = oh;
    @(negedge clk);
    chk({nm, "_grant"}, 64'(bus.req_ready), 64'(oh));
    chk({nm, "_start_early"}, 64'(bus.mul_start), 64'd0);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk({nm, "_start"}, 64'(bus.mul_start), 64'd1);
    chk({nm, "_mul_a"}, 64'(bus.mul_a), 64'(a));
    chk({nm, "_mul_b"}, 64'(bus.mul_b), 64'(b));
    @(negedge clk);
    chk({nm, "_start_pulse"}, 64'(bus.mul_start), 64'd0);
  endtask

  task automatic wait_rsp(input int target, input string nm);
    int n;
    n = 0;
    while (n_rsp < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, "_rsp_seen"}, 64'(n_rsp >= target), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #2 reset = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_product", bus.rsp_product, 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_mul_start", 64'(bus.mul_start), 64'd0);
    chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
    chk("rst_mul_b", 64'(bus.mul_b), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_req_ready", 64'(bus.req_ready), 64'd0);
    end

    // Simple product from requester 0
    tick();
    bus.rsp_ready = 1'b1;
    push_exp(2'd0, 64'd15, 1'b0);
    issue(0, 32'd3, 32'd5, "req0");
    wait_rsp(1, "req0");
    tick();

    // Largest operands from requester 2
    push_exp(2'd2, 64'hFFFF_FFFE_0000_0001, 1'b0);
    issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "req2");
    wait_rsp(2, "req2");
    tick();

    // Backpressure on requester 3; requester 1 pends then drops before any grant
    bus.rsp_ready = 1'b0;
    push_exp(2'd3, 64'd99, 1'b0);
    issue(3, 32'd9, 32'd11, "bp");
    tick();
    bus.req_valid = 4'b0010;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid_seen", 64'(bus.rsp_valid), 64'd1);
    repeat (10) begin
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_rsp_product", bus.rsp_product, 64'd99);
      chk("bp_rsp_id", 64'(bus.rsp_id), 64'd3);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    tick();
    @(negedge clk);
    chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
    chk("bp_skip_dropped", 64'(bus.req_ready), 64'd0);
    chk("bp_rsp_count", 64'(n_rsp), 64'd3);

    // All four requesters held valid: round-robin 0,1,2,3,0
    tick();
    base = n_rsp;
    bus.req_a[31:0]   = 32'd7;          bus.req_b[31:0]   = 32'd6;
    bus.req_a[63:32]  = 32'h0001_0000;  bus.req_b[63:32]  = 32'h0001_0000;
    bus.req_a[95:64]  = 32'd1000;       bus.req_b[95:64]  = 32'd1000;
    bus.req_a[127:96] = 32'hFFFF_FFFF;  bus.req_b[127:96] = 32'd2;
    push_exp(2'd0, 64'd42, 1'b0);
    push_exp(2'd1, 64'h1_0000_0000, 1'b0);
    push_exp(2'd2, 64'd1000000, 1'b0);
    push_exp(2'd3, 64'h1_FFFF_FFFE, 1'b0);
    push_exp(2'd0, 64'd42, 1'b0);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      @(negedge clk);
      #1;
      while (bus.req_ready == '0 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_grant", 64'(bus.req_ready), 64'(1 << order[k]));
      chk("rr_no_overlap", 64'(n_rsp - base), 64'(k));
      tick();
    end
    bus.req_valid = '0;
    wait_rsp(base + 5, "rr");
    tick();

    // Watchdog with multiplier busy stuck high; rr pointer now at 1
    stuck = 1'b1;
    push_exp(2'd1, 64'd0, 1'b1);
    issue(1, 32'd5, 32'd5, "wd");
    n = 2;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wd_latency_in_range", 64'(n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 4), 64'd1);
    wait_rsp(n_rsp + 1, "wd");
    stuck = 1'b0;
    tick();

    // Reset asserted while waiting for busy to fall; no response may follow
    stuck = 1'b1;
    base = n_rsp;
    issue(2, 32'd6, 32'd7, "rst");
    @(negedge clk);
    chk("rst_mid_no_valid", 64'(bus.rsp_valid), 64'd0);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_start", 64'(bus.mul_start), 64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_mid_mul_a", 64'(bus.mul_a), 64'd0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rst_after_valid", 64'(bus.rsp_valid), 64'd0);
    end
    chk("rst_no_rsp", 64'(n_rsp), 64'(base));

    // rr pointer restarted at 0: with 1 and 3 valid, 1 wins
    tick();
    push_exp(2'd1, 64'd15, 1'b0);
    bus.req_a[63:32]  = 32'd3;
    bus.req_b[63:32]  = 32'd5;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("rst_rr_grant", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid = '0;
    wait_rsp(base + 1, "rst_rr");
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
